// File: rtl/seq_mult_feeder_if.sv
// Handshake/bus bundle between a controller and the shift-and-add multiplier feeder.
// The feeder's outputs drive a downstream enable/sync-clear register directly.
interface seq_mult_feeder_if #(
  parameter int DW = 16
);
  localparam int OW = DW / 2;

  logic          start;
  logic          abort;
  logic [OW-1:0] op_a;
  logic [OW-1:0] op_b;
  logic [DW-1:0] product;
  logic          load_en;
  logic          clear_out;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, op_a, op_b,
    input  product, load_en, clear_out, busy, done
  );

  modport slave (
    input  start, abort, op_a, op_b,
    output product, load_en, clear_out, busy, done
  );
endinterface

// File: rtl/seq_mult_feeder.sv
// Fixed-latency unsigned shift-and-add multiplier that feeds a downstream
// enable/sync-clear register: clear_out zeroes it at accept, load_en loads the product.
module seq_mult_feeder #(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_feeder_if.slave  bus
);
  localparam int OW = DW / 2;
  localparam int CW = $clog2(OW + 1);
  localparam logic [CW-1:0] LAST = CW'(OW - 1);

  if ((DW % 2) != 0 || DW < 4) begin : g_bad_dw
    $error("seq_mult_feeder: DW must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [OW-1:0] mplr_q, mplr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          acc_d   = '0;
          mcand_d = {{OW{1'b0}}, bus.op_a};
          mplr_d  = bus.op_b;
          cnt_d   = '0;
        end
      end
      CALC: begin
        // Abort freezes the datapath; acc keeps its partial sum but is never strobed out.
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (mplr_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs only; nothing here looks at the inputs.
  assign bus.product   = acc_q;
  assign bus.load_en   = (state_q == DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.clear_out = (state_q == CALC) && (cnt_q == '0);
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_seq_mult_feeder.sv
// Bench for seq_mult_feeder: scoreboard of expected products checked on each load_en,
// plus per-scenario cycle checks and a model of the downstream enable/sync-clear register.
module tb_seq_mult_feeder;
  localparam int DW = 16;
  localparam int OW = DW / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mult_feeder_if #(.DW(DW)) bus ();

  seq_mult_feeder #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] exp;
    int            k;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_cnt = 0;
  logic [DW-1:0] dreg = '0;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // Downstream register: sync clear wins over enable.
  always @(posedge clk) begin
    if (bus.clear_out)    dreg <= '0;
    else if (bus.load_en) dreg <= bus.product;
  end

  always @(negedge clk) begin
    sb_t e;
    checks++;
    if (bus.done !== bus.load_en) begin
      errors++;
      $display("FAIL done_eq_load_en: done=%b load_en=%b", bus.done, bus.load_en);
    end
    if (bus.load_en === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_load_en: edge=%0d product=%0d, no result pending", edge_cnt, bus.product);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (bus.product !== e.exp) begin
          errors++;
          $display("FAIL product: got %0d expected %0d", bus.product, e.exp);
        end
        checks++;
        if (edge_cnt - e.k != OW) begin
          errors++;
          $display("FAIL latency: got %0d edges expected %0d", edge_cnt - e.k, OW);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; leaves caller in the cycle after the accept edge.
  task automatic start_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input bit push);
    logic [DW-1:0] p;
    p = DW'(a) * DW'(b);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    if (push) sbq.push_back('{p, edge_cnt + 1});
    tick();
    bus.start = 1'b0;
    bus.op_a  = OW'($urandom);
    bus.op_b  = OW'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sbq.size(), budget);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.op_a  = 8'd3;
    bus.op_b  = 8'd5;
    rst = 1'b1;
    tick(); tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.product, bus.load_en, bus.clear_out, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: product=%0d load_en=%b clear=%b busy=%b done=%b required all 0",
               bus.product, bus.load_en, bus.clear_out, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    start_op(8'd13, 8'd11, 1'b1);
    for (int i = 0; i <= OW + 2; i++) begin
      checks++;
      if (bus.clear_out !== (i == 0)) begin
        errors++;
        $display("FAIL basic_clear_out: cycle k+%0d got %b expected %b", i + 1, bus.clear_out, (i == 0));
      end
      checks++;
      if (bus.busy !== (i <= OW)) begin
        errors++;
        $display("FAIL basic_busy: cycle k+%0d got %b expected %b", i + 1, bus.busy, (i <= OW));
      end
      checks++;
      if (bus.load_en !== (i == OW)) begin
        errors++;
        $display("FAIL basic_load_en: cycle k+%0d got %b expected %b", i + 1, bus.load_en, (i == OW));
      end
      tick();
    end
    wait_drain(5);
  endtask

  task automatic test_corners();
    logic [OW-1:0] av[4] = '{8'd255, 8'd0, 8'd200, 8'd1};
    logic [OW-1:0] bv[4] = '{8'd255, 8'd200, 8'd0, 8'd1};
    for (int t = 0; t < 4; t++) begin
      int nld = 0;
      int at  = -1;
      start_op(av[t], bv[t], 1'b1);
      for (int i = 0; i <= OW + 2; i++) begin
        if (bus.load_en === 1'b1) begin
          nld++;
          at = i;
        end
        tick();
      end
      checks++;
      if (nld != 1 || at != OW) begin
        errors++;
        $display("FAIL corner_strobe: %0d*%0d load_en count %0d at cycle %0d, expected 1 at %0d",
                 av[t], bv[t], nld, at, OW);
      end
    end
    wait_drain(5);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3 * (OW + 2); j++) begin
      logic [OW-1:0] a, b;
      a = OW'($urandom_range(0, 255));
      b = OW'($urandom_range(0, 255));
      bus.op_a  = a;
      bus.op_b  = b;
      bus.start = 1'b1;
      if (j % (OW + 2) == 0) sbq.push_back('{DW'(a) * DW'(b), edge_cnt + 1});
      tick();
      checks++;
      if (bus.clear_out !== (j % (OW + 2) == 0)) begin
        errors++;
        $display("FAIL b2b_accept: offset %0d clear_out=%b expected %b",
                 j, bus.clear_out, (j % (OW + 2) == 0));
      end
    end
    bus.start = 1'b0;
    wait_drain(3 * (OW + 2));
  endtask

  task automatic test_abort();
    start_op(8'd100, 8'd3, 1'b0);
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    for (int i = 0; i < OW + 4; i++) begin
      checks++;
      if (bus.load_en !== 1'b0) begin
        errors++;
        $display("FAIL abort_load_en: cycle %0d after abort got %b expected 0", i, bus.load_en);
      end
      tick();
    end
    // start together with abort in IDLE must still be accepted
    bus.abort = 1'b1;
    start_op(8'd50, 8'd2, 1'b1);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b expected 1", bus.busy);
    end
    wait_drain(OW + 4);
  endtask

  task automatic test_rst_mid();
    start_op(8'd20, 8'd20, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.product, bus.load_en, bus.clear_out, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL rst_calc_outputs: product=%0d load_en=%b clear=%b busy=%b required all 0",
               bus.product, bus.load_en, bus.clear_out, bus.busy);
    end
    for (int i = 0; i < OW + 4; i++) begin
      checks++;
      if (bus.load_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_calc_load_en: cycle %0d got %b expected 0", i, bus.load_en);
      end
      tick();
    end
    // Reset asserted during DONE: that strobe is already visible, then everything clears.
    start_op(8'd9, 8'd9, 1'b1);
    for (int i = 0; i < OW; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.product, bus.load_en, bus.clear_out, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL rst_done_outputs: product=%0d load_en=%b clear=%b busy=%b required all 0",
               bus.product, bus.load_en, bus.clear_out, bus.busy);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL rst_done_strobe: %0d results pending, expected 0", sbq.size());
    end
    tick();
    start_op(8'd7, 8'd9, 1'b1);
    wait_drain(OW + 4);
    tick(); tick();
  endtask

  task automatic test_downstream();
    start_op(8'd13, 8'd11, 1'b1);
    tick();
    checks++;
    if (dreg !== 16'd0) begin
      errors++;
      $display("FAIL ds_clear1: reg=%0d expected 0", dreg);
    end
    for (int i = 0; i < OW; i++) tick();
    checks++;
    if (dreg !== 16'd143) begin
      errors++;
      $display("FAIL ds_load1: reg=%0d expected 143", dreg);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ds_idle: busy=%b expected 0", bus.busy);
    end
    start_op(8'd6, 8'd7, 1'b1);
    checks++;
    if (dreg !== 16'd143) begin
      errors++;
      $display("FAIL ds_hold1: reg=%0d expected 143", dreg);
    end
    tick();
    checks++;
    if (dreg !== 16'd0) begin
      errors++;
      $display("FAIL ds_clear2: reg=%0d expected 0", dreg);
    end
    for (int i = 0; i < OW; i++) tick();
    checks++;
    if (dreg !== 16'd42) begin
      errors++;
      $display("FAIL ds_load2: reg=%0d expected 42", dreg);
    end
    tick(); tick();
    checks++;
    if (dreg !== 16'd42) begin
      errors++;
      $display("FAIL ds_hold2: reg=%0d expected 42", dreg);
    end
    wait_drain(4);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_downstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_mult_feeder.md
Name: seq_mult_feeder

Overview:
- Sequential unsigned shift-and-add multiplier that sits directly upstream of the team's enable/sync-clear output register.
- Accepts two operands on a start pulse and computes their product over OW cycles.
- Drives the downstream register's data input, enable and sync-clear.
- The result is presented for exactly one cycle, qualified by load_en, and the downstream register holds it after that.

Parameters:
- DW, 16, product width; must match the downstream register width; must be even and >= 4.
- OW, DW/2, operand width (derived; not to be overridden independently).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel of an in-flight operation.
- op_a  input  OW  multiplicand, unsigned; captured on accepted start.
- op_b  input  OW  multiplier, unsigned; captured on accepted start.
- product  output  DW  accumulator contents; valid only when load_en=1. Feeds downstream Data_Input.
- load_en  output  1  one-cycle result strobe. Feeds downstream enable.
- clear_out  output  1  one-cycle pulse that zeroes the downstream register at the start of an operation. Feeds downstream Sync_Reset.
- busy  output  1  high from accept until the end of the DONE cycle.
- done  output  1  equals load_en; provided for the controller.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - Accumulator, multiplicand shift register (DW bits), multiplier shift register (OW bits) and iteration counter (clog2(OW+1) bits) all 0.
  - Every output is 0 from the following cycle.
  - rst has priority over abort and start, including mid-operation; no load_en is produced.
- States: IDLE, CALC, DONE; registered state.
  - All outputs are decoded from registered state/counters (Moore); there are no combinational paths from inputs to outputs.
- IDLE:
  - start=1 at edge k: capture mcand={OW'0,op_a}, mplr=op_b, acc=0, cnt=0; go to CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per edge:
  - if mplr[0]: acc <= acc + mcand (DW-bit, no overflow possible since OW+OW=DW).
  - mcand <= mcand<<1; mplr <= mplr>>1; cnt <= cnt+1.
  - After the OW-th iteration (edge k+OW) go to DONE.
  - No early termination when mplr reaches 0; latency is fixed.
- DONE: lasts one cycle, then IDLE at edge k+OW+1.
- Output timing relative to accept edge k:
  - clear_out=1 during the cycle after edge k (CALC, cnt=0) only.
  - busy=1 from after edge k through the DONE cycle.
  - load_en=done=1 during the cycle after edge k+OW only, with product=op_a*op_b.
  - Start-to-result latency is OW+1 cycles; a new start can be accepted no earlier than edge k+OW+2, giving a throughput of one result per OW+2 cycles.
- start while busy (CALC or DONE): ignored; there is no queuing and the operands are not sampled.
- abort=1 at an edge while in CALC: go to IDLE; acc is unchanged but product is don't-care; load_en is not asserted; the downstream register keeps the 0 written by clear_out.
  - abort in IDLE or DONE: no effect; the DONE strobe still completes.
- Simultaneous start and abort in IDLE: start wins; the operation is accepted.
- product outside load_en cycles: reflects acc (deterministic, 0 after reset); the downstream side must qualify it with load_en.
- Operand changes after the accept edge have no effect on the result.

Test Plan:
1. Reset, then op_a=13, op_b=11, start pulse at edge k → clear_out=1 only in cycle k+1; busy=1 for cycles k+1..k+9; load_en=done=1 only in cycle k+9 (OW=8) with product=143; IDLE at k+10.
2. Corner operands: 255*255 → 65025 (0xFE01); 0*200 → 0; 200*0 → 0; 1*1 → 1. Each gives load_en exactly once, with latency 9 cycles.
3. Hold start=1 continuously with operands changing every cycle → one accept per 10 cycles; each product matches the operands sampled at its accept edge; no start is accepted during CALC or DONE.
4. abort at the 4th CALC cycle of 100*3 → busy drops after the abort edge; load_en never asserts; the next start 50*2 yields 100 normally.
5. rst=1 mid-CALC, and separately during DONE → from the following cycle all outputs are 0 and state is IDLE; no load_en after reset; a following start 7*9 yields 63.
6. Integrated with the downstream register (DW=16), back-to-back 13*11 then 6*7 → register output goes to 0 after the clear_out pulse, holds 143 after the first load_en, clears on the next clear_out, then holds 42.
